// File: rtl/ysyx_22040931_hazard_sb_pkg.sv
// Shared encodings and default parameters for the decode-stage hazard unit.
package ysyx_22040931_hazard_sb_pkg;

  // Stall cause bit positions inside stall_cause
  localparam int STALL_RAW    = 0;
  localparam int STALL_WAW    = 1;
  localparam int STALL_STRUCT = 2;
  localparam int CAUSE_W      = 3;

  // One-hot cause encodings, zero when not stalling
  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE   = 3'b000,
    CAUSE_RAW    = 3'b001,
    CAUSE_WAW    = 3'b010,
    CAUSE_STRUCT = 3'b100
  } stall_cause_e;

  // Default parameter values
  localparam int DEF_XLEN    = 64;
  localparam int DEF_NREG    = 32;
  localparam int DEF_NRD     = 2;
  localparam int DEF_NFWD    = 2;
  localparam int DEF_MAXLONG = 4;
  localparam int DEF_CNTW    = 32;

endpackage

// File: rtl/ysyx_22040931_hazard_sb_fwd_sel.sv
// Single source-operand priority bypass mux. Stage 0 (youngest) wins over
// older stages, then the long-op writeback, then the register file.
module ysyx_22040931_hazard_sb_fwd_sel #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NFWD = 2
) (
  input  logic              i_rs_ena,
  input  logic [AW-1:0]     i_rs_addr,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [NFWD-1:0]   i_fwd_ena,
  input  logic [NFWD*AW-1:0]   i_fwd_addr,
  input  logic [NFWD*XLEN-1:0] i_fwd_data,
  input  logic [NFWD-1:0]   i_fwd_rdy,
  input  logic              i_done_ena,
  input  logic [AW-1:0]     i_done_addr,
  input  logic [XLEN-1:0]   i_done_data,
  output logic [XLEN-1:0]   o_op,
  output logic              o_hit_nrdy
);

  logic            w_hit;
  logic            w_frdy;
  logic [XLEN-1:0] w_fdata;

  // Find the youngest matching stage: walk oldest to youngest so the
  // lowest index overwrites.
  always_comb begin
    w_hit   = 1'b0;
    w_frdy  = 1'b1;
    w_fdata = '0;
    for (int k = NFWD-1; k >= 0; k--) begin
      if (i_fwd_ena[k] && (i_fwd_addr[k*AW +: AW] == i_rs_addr)) begin
        w_hit   = 1'b1;
        w_frdy  = i_fwd_rdy[k];
        w_fdata = i_fwd_data[k*XLEN +: XLEN];
      end
    end
  end

  // Operand select; x0 never bypasses and never waits on a stage
  always_comb begin
    o_op       = i_rf_data;
    o_hit_nrdy = 1'b0;
    if (!i_rs_ena) begin
      o_op = i_imm;
    end else if (i_rs_addr == '0) begin
      o_op = '0;
    end else if (w_hit) begin
      o_op       = w_fdata;
      o_hit_nrdy = ~w_frdy;
    end else if (i_done_ena && (i_done_addr == i_rs_addr)) begin
      o_op = i_done_data;
    end
  end

endmodule

// File: rtl/ysyx_22040931_hazard_sb.sv
// Decode-stage operand forwarding and hazard unit with a long-latency
// scoreboard, outstanding-op limit and saturating stall counter.
module ysyx_22040931_hazard_sb
  import ysyx_22040931_hazard_sb_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int NRD     = DEF_NRD,
  parameter int NFWD    = DEF_NFWD,
  parameter int MAXLONG = DEF_MAXLONG,
  parameter int CNTW    = DEF_CNTW,
  localparam int AW     = $clog2(NREG),
  localparam int OW     = $clog2(MAXLONG+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic                 flush,
  input  logic [NRD-1:0]       rs_ena,
  input  logic [NRD*AW-1:0]    rs_addr,
  input  logic [NRD*XLEN-1:0]  rf_data,
  input  logic [XLEN-1:0]      imm,
  input  logic                 rd_ena,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 id_long,
  input  logic [NFWD-1:0]      fwd_ena,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 done_ena,
  input  logic [AW-1:0]        done_addr,
  input  logic [XLEN-1:0]      done_data,
  output logic [NRD*XLEN-1:0]  op_data,
  output logic                 stall,
  output logic [CAUSE_W-1:0]   stall_cause,
  output logic [NREG-1:0]      pend_vec,
  output logic [OW-1:0]        outstanding,
  output logic [CNTW-1:0]      stall_cnt
);

  logic [NREG-1:0] r_pend;
  logic [OW-1:0]   r_out;
  logic [CNTW-1:0] r_cnt;

  logic [NRD-1:0]  w_fwd_nrdy;
  logic [NRD-1:0]  w_sb_hit;
  logic            w_raw, w_waw, w_struct;
  logic            w_issue, w_set, w_done, w_inc;
  logic [NREG-1:0] w_pend_nxt;
  logic [OW-1:0]   w_out_nxt;

  // Per-port bypass mux plus scoreboard lookup
  for (genvar g = 0; g < NRD; g++) begin : gen_port
    logic [AW-1:0] w_a;
    assign w_a = rs_addr[g*AW +: AW];

    ysyx_22040931_hazard_sb_fwd_sel #(
      .XLEN (XLEN),
      .AW   (AW),
      .NFWD (NFWD)
    ) u_sel (
      .i_rs_ena    (rs_ena[g]),
      .i_rs_addr   (w_a),
      .i_rf_data   (rf_data[g*XLEN +: XLEN]),
      .i_imm       (imm),
      .i_fwd_ena   (fwd_ena),
      .i_fwd_addr  (fwd_addr),
      .i_fwd_data  (fwd_data),
      .i_fwd_rdy   (fwd_rdy),
      .i_done_ena  (done_ena),
      .i_done_addr (done_addr),
      .i_done_data (done_data),
      .o_op        (op_data[g*XLEN +: XLEN]),
      .o_hit_nrdy  (w_fwd_nrdy[g])
    );

    // Pending register not being written back this very cycle
    assign w_sb_hit[g] = rs_ena[g] && (w_a != '0) && r_pend[w_a] &&
                         !(done_ena && (done_addr == w_a));
  end

  assign w_raw    = |w_fwd_nrdy || |w_sb_hit;
  assign w_waw    = rd_ena && (rd_addr != '0) && r_pend[rd_addr] &&
                    !(done_ena && (done_addr == rd_addr));
  assign w_struct = id_long && (r_out == OW'(MAXLONG)) && !done_ena;
  assign stall    = id_valid && !flush && (w_raw || w_waw || w_struct);

  // Report only the highest-priority cause
  always_comb begin
    stall_cause = CAUSE_NONE;
    if (stall) begin
      if (w_raw)      stall_cause = CAUSE_RAW;
      else if (w_waw) stall_cause = CAUSE_WAW;
      else            stall_cause = CAUSE_STRUCT;
    end
  end

  // Any issued long op occupies a slot, even with rd=x0; only real
  // destinations get a pending bit.
  assign w_issue = id_valid && !stall && !flush && id_long;
  assign w_set   = w_issue && rd_ena && (rd_addr != '0);
  assign w_done  = done_ena && (r_out != '0);
  assign w_inc   = w_issue && ((r_out != OW'(MAXLONG)) || w_done);

  // Scoreboard next state: clear then set, so same-register issue+done keeps the bit
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_done) w_pend_nxt[done_addr] = 1'b0;
    if (w_set)  w_pend_nxt[rd_addr]   = 1'b1;
    w_pend_nxt[0] = 1'b0;
    w_out_nxt = r_out;
    if (w_inc && !w_done)      w_out_nxt = r_out + 1'b1;
    else if (!w_inc && w_done) w_out_nxt = r_out - 1'b1;
  end

  // Scoreboard, outstanding count and saturating stall counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_out  <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_out  <= w_out_nxt;
      if (stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  // A writeback with nothing in flight indicates an upstream bug
  a_done_underflow: assert property (@(posedge clock) disable iff (!reset)
    done_ena |-> (r_out != '0));

  assign pend_vec    = r_pend;
  assign outstanding = r_out;
  assign stall_cnt   = r_cnt;

endmodule
